disp_buf_writer: RTL and testbench

Text-buffer write-port arbiter sitting directly downstream of the screen-clear sweep engine. It converts the sweep engine's (x, y) character positions and the CPU's character-write requests into single-port text-RAM writes (linear address y*80+x). Clear writes have absolute priority because the sweep engine cannot stall. CPU writes are queued in a small FIFO and drained in order when no clear is in progress.

---
 rtl/disp_buf_writer_pkg.sv | 14 +
 rtl/disp_wr_fifo.sv | 31 +++
 rtl/disp_buf_writer.sv | 61 ++++++
 tb/tb_disp_buf_writer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/disp_buf_writer_pkg.sv
// disp_buf_writer_pkg: shared display geometry, writer FSM encoding and xy->address mapping
package disp_buf_writer_pkg;
  localparam int MAX_X = 80;
  localparam int MAX_Y = 30;
  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam int ADDR_W = 12;
  typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;
  // y*80 + x as shifts so no multiplier is inferred
  function automatic logic [ADDR_W-1:0] xy_addr(input logic [6:0] x, input logic [4:0] y);
    logic [ADDR_W-1:0] yy;
    yy = {{(ADDR_W-5){1'b0}}, y};
    return (yy << 6) + (yy << 4) + {{(ADDR_W-7){1'b0}}, x};
  endfunction
endpackage

// File: rtl/disp_wr_fifo.sv
// disp_wr_fifo: first-word fall-through synchronous FIFO for queued CPU text writes
module disp_wr_fifo #(
  parameter int W = 20,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + (AW+1)'(1);
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
endmodule

// File: rtl/disp_buf_writer.sv
// disp_buf_writer: arbitrates clear-sweep and queued CPU writes onto the single text-RAM port
module disp_buf_writer import disp_buf_writer_pkg::*; #(
  parameter int MAX_X = 80,
  parameter int MAX_Y = 30,
  parameter int FIFO_DEPTH = 4,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_busy,
  input  logic [6:0]        clr_x,
  input  logic [4:0]        clr_y,
  input  logic              cpu_wr_valid,
  output logic              cpu_wr_ready,
  input  logic [6:0]        cpu_x,
  input  logic [4:0]        cpu_y,
  input  logic [7:0]        cpu_char,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              clear_done,
  output logic              wr_drop
);
  logic full, empty, push, pop, in_range;
  logic [19:0] head;
  logic [6:0] hx;
  logic [4:0] hy;
  logic [7:0] hc;
  state_t state;
  assign cpu_wr_ready = !full;
  assign push = cpu_wr_valid && !full;
  // the sweep engine cannot stall, so any clear cycle blocks the FIFO pop
  assign pop = !clr_busy && !empty;
  assign {hx, hy, hc} = head;
  assign in_range = ({25'd0, hx} < MAX_X) && ({27'd0, hy} < MAX_Y);
  disp_wr_fifo #(.W(20), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop),
    .din({cpu_x, cpu_y, cpu_char}), .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      clear_done <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      state <= clr_busy ? CLEAR : (empty ? IDLE : DRAIN);
      ram_we <= clr_busy || (pop && in_range);
      wr_drop <= pop && !in_range;
      clear_done <= (state == CLEAR) && !clr_busy;
      if (clr_busy) begin
        ram_addr <= xy_addr(clr_x, clr_y);
        ram_wdata <= BLANK_CHAR;
      end else if (pop && in_range) begin
        ram_addr <= xy_addr(hx, hy);
        ram_wdata <= hc;
      end
    end
endmodule

// File: tb/tb_disp_buf_writer.sv
// tb_disp_buf_writer: vector table plus scoreboarded sweep, backpressure and reset sequences
module tb_disp_buf_writer;
  logic clk = 1'b0, reset_n = 1'b0;
  logic clr_busy = 1'b0, cpu_wr_valid = 1'b0, cpu_wr_ready;
  logic [6:0] clr_x = '0, cpu_x = '0;
  logic [4:0] clr_y = '0, cpu_y = '0;
  logic [7:0] cpu_char = '0, ram_wdata;
  logic ram_we, clear_done, wr_drop;
  logic [11:0] ram_addr;
  always #5 clk = ~clk;
  disp_buf_writer dut (
    .clk(clk), .reset_n(reset_n), .clr_busy(clr_busy), .clr_x(clr_x), .clr_y(clr_y),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready), .cpu_x(cpu_x), .cpu_y(cpu_y),
    .cpu_char(cpu_char), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .clear_done(clear_done), .wr_drop(wr_drop)
  );
  typedef struct {logic [6:0] x; logic [4:0] y; logic [7:0] ch;} ent_t;
  typedef struct {logic we; logic [11:0] addr; logic [7:0] data; logic drop; logic done;} exp_t;
  typedef struct {logic b; logic [6:0] x; logic [4:0] y; logic [7:0] ch; logic we; logic [11:0] addr; logic drop;} vec_t;
  ent_t mq[$];
  exp_t sq[$];
  int checks = 0, failures = 0, done_cnt = 0, we_cnt = 0;
  logic prev_b = 1'b0, last_we, last_drop;
  logic [11:0] last_addr;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask
  task automatic step(input logic b, input logic [6:0] x, input logic [4:0] y, input logic v,
                      input logic [6:0] cx, input logic [4:0] cy, input logic [7:0] ch, output logic acc);
    exp_t e;
    ent_t h;
    logic rdy;
    @(negedge clk);
    rdy = cpu_wr_ready;
    chk("cpu_wr_ready", rdy, mq.size() < 4);
    clr_busy = b; clr_x = x; clr_y = y;
    cpu_wr_valid = v; cpu_x = cx; cpu_y = cy; cpu_char = ch;
    acc = v && rdy;
    e = '{we: 1'b0, addr: 12'd0, data: 8'd0, drop: 1'b0, done: prev_b && !b};
    if (b) begin
      e.we = 1'b1; e.addr = 12'(int'(y) * 80 + int'(x)); e.data = 8'h20;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      if (h.x < 80 && h.y < 30) begin
        e.we = 1'b1; e.addr = 12'(int'(h.y) * 80 + int'(h.x)); e.data = h.ch;
      end else e.drop = 1'b1;
    end
    prev_b = b;
    if (acc) mq.push_back('{x: cx, y: cy, ch: ch});
    sq.push_back(e);
    @(posedge clk);
    #1;
    e = sq.pop_front();
    chk("ram_we", ram_we, e.we);
    if (e.we) begin
      chk("ram_addr", ram_addr, e.addr);
      chk("ram_wdata", ram_wdata, e.data);
    end
    chk("wr_drop", wr_drop, e.drop);
    chk("clear_done", clear_done, e.done);
    if (ram_we) we_cnt++;
    if (clear_done) done_cnt++;
    last_we = ram_we; last_drop = wr_drop; last_addr = ram_addr;
  endtask
  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 7'd0, 5'd0, 1'b0, 7'd0, 5'd0, 8'd0, a);
  endtask
  task automatic rst_pulse();
    @(negedge clk);
    clr_busy = 1'b0; cpu_wr_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_clear_done", clear_done, 0);
    chk("rst_wr_drop", wr_drop, 0);
    chk("rst_ready", cpu_wr_ready, 1);
    mq.delete(); sq.delete(); prev_b = 1'b0;
    #2 reset_n = 1'b1;
  endtask
  initial begin
    vec_t vt[10];
    logic acc;
    int k, d0, w0;
    vt[0] = '{1'b1, 7'd0, 5'd0, 8'h00, 1'b1, 12'd0, 1'b0};
    vt[1] = '{1'b1, 7'd79, 5'd0, 8'h00, 1'b1, 12'd79, 1'b0};
    vt[2] = '{1'b1, 7'd0, 5'd1, 8'h00, 1'b1, 12'd80, 1'b0};
    vt[3] = '{1'b1, 7'd79, 5'd29, 8'h00, 1'b1, 12'd2399, 1'b0};
    vt[4] = '{1'b0, 7'd5, 5'd2, 8'h41, 1'b1, 12'd165, 1'b0};
    vt[5] = '{1'b0, 7'd80, 5'd0, 8'h55, 1'b0, 12'd0, 1'b1};
    vt[6] = '{1'b0, 7'd0, 5'd30, 8'h56, 1'b0, 12'd0, 1'b1};
    vt[7] = '{1'b0, 7'd127, 5'd31, 8'h57, 1'b0, 12'd0, 1'b1};
    vt[8] = '{1'b0, 7'd79, 5'd29, 8'h7e, 1'b1, 12'd2399, 1'b0};
    vt[9] = '{1'b0, 7'd40, 5'd15, 8'h33, 1'b1, 12'd1240, 1'b0};
    rst_pulse();
    idle(10);
    foreach (vt[i]) begin
      if (vt[i].b) begin
        step(1'b1, vt[i].x, vt[i].y, 1'b0, 7'd0, 5'd0, 8'd0, acc);
        chk("tbl_we", last_we, vt[i].we);
        if (vt[i].we) chk("tbl_addr", last_addr, vt[i].addr);
        chk("tbl_drop", last_drop, vt[i].drop);
        idle(1);
      end else begin
        step(1'b0, 7'd0, 5'd0, 1'b1, vt[i].x, vt[i].y, vt[i].ch, acc);
        idle(1);
        chk("tbl_we", last_we, vt[i].we);
        if (vt[i].we) chk("tbl_addr", last_addr, vt[i].addr);
        chk("tbl_drop", last_drop, vt[i].drop);
      end
      idle(2);
    end
    k = 0; d0 = done_cnt; w0 = we_cnt;
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 80; x++) begin
        step(1'b1, 7'(x), 5'(y), k < 6, 7'(k), 5'd10, 8'(8'h60 + k), acc);
        if (acc) k++;
      end
    chk("accepted_during_clear", k, 4);
    chk("sweep_writes", we_cnt - w0, 2400);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 7'd0, 5'd0, k < 6, 7'(k), 5'd10, 8'(8'h60 + k), acc);
      if (acc) k++;
    end
    chk("accepted_total", k, 6);
    chk("clear_done_pulses", done_cnt - d0, 1);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 7'(i % 80), 5'(i / 80), k < 3, 7'(k), 5'd3, 8'h70, acc);
      if (acc) k++;
    end
    chk("queued_before_reset", mq.size(), 3);
    w0 = we_cnt;
    rst_pulse();
    idle(10);
    chk("writes_after_reset", we_cnt - w0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
